// File: rtl/datamem_pkg.sv
// Shared constants, word type and index helper for the data memory.
// Defaults: 32-bit address, 32-bit words, 1024 words.
package datamem_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int DEPTH_LOG2 = 10;
  localparam int DEPTH      = 1 << DEPTH_LOG2;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [DEPTH_LOG2-1:0] idx_t;

  // Word index: low address bits, upper bits alias.
  function automatic idx_t idx_of(
    input logic [ADDR_WIDTH-1:0] address
  );
    return address[DEPTH_LOG2-1:0];
  endfunction

endpackage

// File: rtl/datamem_range_check.sv
// Flags a word address whose upper bits are nonzero (outside the array).
// Ports: hi (upper address bits), oor (out-of-range flag).
module datamem_range_check #(
  parameter int HI_WIDTH = 22
) (
  input  logic [HI_WIDTH-1:0] hi,
  output logic                oor
);

  assign oor = |hi;

endmodule

// File: rtl/data_memory.sv
// Word-addressed single-port data memory, registered read, read-before-write.
// Ports: clk, rst_n (async, active-low), address, MemWrite, MemRead,
//   writeData, readData; addrError only with DATAMEM_RANGE_CHECK_EN.
module data_memory
  import datamem_pkg::*;
#(
  parameter int ADDR_WIDTH = datamem_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = datamem_pkg::DATA_WIDTH,
  parameter int DEPTH_LOG2 = datamem_pkg::DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData
`ifdef DATAMEM_RANGE_CHECK_EN
  ,
  output logic                  addrError
`endif
);

  localparam int NWORDS = 1 << DEPTH_LOG2;
  localparam int HI_W   = ADDR_WIDTH - DEPTH_LOG2;

  logic [DATA_WIDTH-1:0] mem [NWORDS];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  ok;
  logic                  we;
  logic                  re;

  assign idx = address[DEPTH_LOG2-1:0];

`ifdef DATAMEM_RANGE_CHECK_EN
  logic oor;

  datamem_range_check #(
    .HI_WIDTH (HI_W)
  ) u_rc (
    .hi  (address[ADDR_WIDTH-1:DEPTH_LOG2]),
    .oor (oor)
  );

  assign ok = ~oor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrError <= 1'b0;
    end else begin
      addrError <= oor & (MemRead | MemWrite);
    end
  end
`else
  // Upper bits alias onto the array when range checking is off.
  logic unused_hi;
  assign unused_hi = ^address[ADDR_WIDTH-1:DEPTH_LOG2];
  assign ok        = 1'b1;
`endif

  assign we = MemWrite & ok;
  assign re = MemRead;

  // Whole array clears on reset so unwritten words read as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NWORDS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[idx] <= writeData;
    end
  end

  // Samples the pre-edge word, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      readData <= '0;
    end else if (re) begin
      readData <= ok ? mem[idx] : '0;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed self-checking bench for data_memory.
// Covers both builds (DATAMEM_RANGE_CHECK_EN defined or not).
module tb_data_memory;

  import datamem_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] address;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] writeData;
  logic [31:0] readData;
`ifdef DATAMEM_RANGE_CHECK_EN
  logic        addrError;
`endif

  int total = 0;
  int bad   = 0;

  data_memory dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address   (address),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .writeData (writeData),
    .readData  (readData)
`ifdef DATAMEM_RANGE_CHECK_EN
    ,
    .addrError (addrError)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    address   = a;
    writeData = d;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    cyc();
    MemWrite  = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] d);
    address   = a;
    writeData = d;
    MemWrite  = 1'b0;
    MemRead   = 1'b1;
    cyc();
    MemRead   = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    address   = '0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    writeData = '0;
    #1;
    check("reset_rd", readData, 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    rd(32'd0, 32'h0);
    check("undriven0", readData, 32'h0);

    // 1: write 16 to addr 1, read with different writeData
    wr(32'd1, 32'd16);
    rd(32'd1, 32'd18);
    check("t1_rd1", readData, 32'd16);

    // 2: full-width value, no cross-talk
    wr(32'd2, 32'd99999999);
    rd(32'd2, 32'd0);
    check("t2_rd2", readData, 32'h05F5_E0FF);
    rd(32'd1, 32'd0);
    check("t2_rd1", readData, 32'd16);

    // 3: idle cycle holds readData
    wr(32'd5, 32'hDEAD_BEEF);
    address   = 32'd7;
    writeData = 32'h1234_5678;
    cyc();
    check("t3_hold", readData, 32'd16);
    rd(32'd5, 32'h0);
    check("t3_rd5", readData, 32'hDEAD_BEEF);

    // write without read does not forward
    wr(32'd5, 32'hCAFE_F00D);
    check("no_fwd", readData, 32'hDEAD_BEEF);

    // 4: read-before-write
    wr(32'd3, 32'h1111_1111);
    address   = 32'd3;
    writeData = 32'h2222_2222;
    MemWrite  = 1'b1;
    MemRead   = 1'b1;
    cyc();
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    check("t4_rbw", readData, 32'h1111_1111);
    rd(32'd3, 32'h0);
    check("t4_new", readData, 32'h2222_2222);

    // top word is distinct from word 0
    wr(32'd1023, 32'hFFFF_FFFF);
    rd(32'd0, 32'h0);
    check("w0_clean", readData, 32'h0);
    rd(32'd1023, 32'h0);
    check("w1023", readData, 32'hFFFF_FFFF);
    rd(32'd6, 32'h0);
    check("undriven6", readData, 32'h0);

    // 5: async reset mid-cycle
    wr(32'd4, 32'hA5A5_A5A5);
    rd(32'd4, 32'h0);
    check("t5_rd4", readData, 32'hA5A5_A5A5);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async", readData, 32'h0);
    cyc();
    rst_n = 1'b1;
    rd(32'd4, 32'h0);
    check("t5_clr4", readData, 32'h0);
    rd(32'd1023, 32'h0);
    check("t5_clr1023", readData, 32'h0);

    // 6: upper address bits
    wr(32'd1, 32'h0000_0077);
    wr(32'h0000_0401, 32'h0000_0042);
`ifdef DATAMEM_RANGE_CHECK_EN
    check("t6_err_wr", 32'(addrError), 32'd1);
    rd(32'd1, 32'h0);
    check("t6_rd1", readData, 32'h0000_0077);
    check("t6_err_ok", 32'(addrError), 32'd0);
    rd(32'h0000_0401, 32'h0);
    check("t6_rd401", readData, 32'h0);
    check("t6_err_rd", 32'(addrError), 32'd1);
    cyc();
    check("t6_err_idle", 32'(addrError), 32'd0);
`else
    rd(32'd1, 32'h0);
    check("t6_alias", readData, 32'h0000_0042);
    rd(32'h8000_0002, 32'h0);
    check("t6_alias2", readData, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
